// File: rtl/register_file_scoreboard.sv
// register_file_scoreboard
// Integer register file with a per-register pending-write scoreboard. Issue
// side reads two operands and receives the stall decision; write-back side
// writes results and retires pending counts.
//
// Optional feature: define RF_WB_BYPASS_EN to forward same-cycle write-back
// data to an operand whose only outstanding write is the one completing.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   issue_valid_i / issue_ready_o issue handshake (ready is combinational)
//   issue_rs{1,2}_en_i, _i        operand enables and addresses
//   issue_rd_en_i, issue_rd_i     destination enable and address
//   rs{1,2}_data_o                operand data (combinational)
//   wb_valid_i, wb_rd_i, wb_data_i write-back port
//   flush_i                       clears all pending counts
//   sb_err_o                      sticky: write-back with zero pending count
module register_file_scoreboard #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned AW     = $clog2(NREG),
  parameter int unsigned PEND_W = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic            issue_rs1_en_i,
  input  logic [AW-1:0]   issue_rs1_i,
  input  logic            issue_rs2_en_i,
  input  logic [AW-1:0]   issue_rs2_i,
  input  logic            issue_rd_en_i,
  input  logic [AW-1:0]   issue_rd_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic            wb_valid_i,
  input  logic [AW-1:0]   wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            flush_i,
  output logic            sb_err_o
);

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  logic [XLEN-1:0]   regs_q [NREG];
  logic [XLEN-1:0]   regs_d [NREG];
  logic [PEND_W-1:0] pend_q [NREG];
  logic [PEND_W-1:0] pend_d [NREG];
  logic              sb_err_q, sb_err_d;

  logic [PEND_W-1:0] rs1_pend, rs2_pend, rd_pend;
  logic              rs1_byp, rs2_byp;
  logic              rs1_ready, rs2_ready, rd_full, fire;
  logic [NREG-1:0]   inc_vec, dec_vec;

  assign rs1_pend = pend_q[issue_rs1_i];
  assign rs2_pend = pend_q[issue_rs2_i];
  assign rd_pend  = pend_q[issue_rd_i];

  // Forwarding hit: the completing write-back is the only outstanding one.
`ifdef RF_WB_BYPASS_EN
  assign rs1_byp = (issue_rs1_i != '0) && (rs1_pend == PEND_W'(1)) &&
                   wb_valid_i && (wb_rd_i == issue_rs1_i);
  assign rs2_byp = (issue_rs2_i != '0) && (rs2_pend == PEND_W'(1)) &&
                   wb_valid_i && (wb_rd_i == issue_rs2_i);
`else
  assign rs1_byp = 1'b0;
  assign rs2_byp = 1'b0;
`endif

  assign rs1_ready = !issue_rs1_en_i || (issue_rs1_i == '0) ||
                     (rs1_pend == '0) || rs1_byp;
  assign rs2_ready = !issue_rs2_en_i || (issue_rs2_i == '0) ||
                     (rs2_pend == '0) || rs2_byp;

  // A same-cycle write-back to rd frees a slot, so a full counter may still issue.
  assign rd_full = issue_rd_en_i && (issue_rd_i != '0) && (rd_pend == PEND_MAX) &&
                   !(wb_valid_i && (wb_rd_i == issue_rd_i));

  assign issue_ready_o = rs1_ready && rs2_ready && !rd_full && !flush_i;
  assign fire          = issue_valid_i && issue_ready_o;
  assign sb_err_o      = sb_err_q;

  // Operand read mux
  always_comb begin
    rs1_data_o = '0;
    rs2_data_o = '0;
    if (issue_rs1_en_i && (issue_rs1_i != '0)) begin
      if (rs1_byp)              rs1_data_o = wb_data_i;
      else if (rs1_pend == '0)  rs1_data_o = regs_q[issue_rs1_i];
    end
    if (issue_rs2_en_i && (issue_rs2_i != '0)) begin
      if (rs2_byp)              rs2_data_o = wb_data_i;
      else if (rs2_pend == '0)  rs2_data_o = regs_q[issue_rs2_i];
    end
  end

  // Per-register increment/decrement requests; register 0 never tracked
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < NREG; r++) begin
      inc_vec[r] = fire && issue_rd_en_i && (issue_rd_i == AW'(r));
      dec_vec[r] = wb_valid_i && (wb_rd_i == AW'(r));
    end
  end

  // Next-state for data, counters and the error flag
  always_comb begin
    regs_d   = regs_q;
    pend_d   = pend_q;
    sb_err_d = sb_err_q;
    if (wb_valid_i && (wb_rd_i != '0)) regs_d[wb_rd_i] = wb_data_i;
    for (int r = 1; r < NREG; r++) begin
      // Underflow: hold at zero and raise the sticky flag
      if (dec_vec[r] && !inc_vec[r] && (pend_q[r] == '0)) sb_err_d = 1'b1;
      if (flush_i) begin
        pend_d[r] = '0;
      end else if (inc_vec[r] && !dec_vec[r]) begin
        pend_d[r] = pend_q[r] + PEND_W'(1);
      end else if (dec_vec[r] && !inc_vec[r] && (pend_q[r] != '0)) begin
        pend_d[r] = pend_q[r] - PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
        pend_q[i] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      pend_q   <= pend_d;
      sb_err_q <= sb_err_d;
    end
  end

endmodule
